// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA modular exponentiation engine.
// Holds the engine FSM state encoding and the default key width.
package rsa_pkg;

  localparam int KEY_WIDTH_DEF = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_UPDATE,
    ST_FIN
  } state_e;

endpackage

// File: rtl/rsa_modmul_serial.sv
// Serial MSB-first interleaved shift-add modular multiplier: p = a*b mod n.
// W cycles per product; done is high in the final step cycle, p valid after it.
module rsa_modmul_serial
  import rsa_pkg::*;
#(
  parameter int W = KEY_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         done,
  output logic [W-1:0] p
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  n_q, n_d;
  logic [W+1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [W+1:0]  t0, t1, t2, nx;

  // One step: acc = 2*acc + a_msb*b, then reduce by n at most twice.
  always_comb begin
    nx = {2'b00, n_q};
    t0 = {acc_q[W:0], 1'b0} + (a_q[W-1] ? {2'b00, b_q} : '0);
    t1 = (t0 >= nx) ? t0 - nx : t0;
    t2 = (t1 >= nx) ? t1 - nx : t1;
  end

  // Load operands on start, otherwise advance one bit per cycle while busy.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    n_d    = n_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      a_d    = a;
      b_d    = b;
      n_d    = n;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = t2;
      a_d   = a_q << 1;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(W - 1)) busy_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      n_q    <= n_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done = busy_q && (cnt_q == CW'(W - 1));
  assign p    = acc_q[W-1:0];

endmodule

// File: rtl/rsa_modexp_engine.sv
// Constant-time right-to-left binary modular exponentiation r = c^d mod n.
// Optional RSA_MODEXP_CYCLE_CNT_EN adds a saturating 32-bit cycle_cnt output.
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int KEY_WIDTH = KEY_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [KEY_WIDTH-1:0] c,
  input  logic [KEY_WIDTH-1:0] d,
  input  logic [KEY_WIDTH-1:0] n,
  output logic                 ready,
  output logic                 done,
  output logic                 err,
  output logic [KEY_WIDTH-1:0] r
`ifdef RSA_MODEXP_CYCLE_CNT_EN
  ,
  output logic [31:0]          cycle_cnt
`endif
);

  localparam int KW = KEY_WIDTH;
  localparam int IW = $clog2(KEY_WIDTH);

  state_e        state_q, state_d;
  logic [KW-1:0] c_q, c_d, d_q, d_d, n_q, n_d;
  logic [KW-1:0] base_q, base_d, res_q, res_d;
  logic [KW-1:0] r_q, r_d;
  logic [IW-1:0] bit_q, bit_d;
  logic          err_q, err_d, err_p_q, err_p_d;
  logic          done_q, done_d, ready_q, ready_d;
  logic          mul_start, pr_done, sq_done, mul_done;
  logic [KW-1:0] pr_p, sq_p;

  assign mul_done = pr_done & sq_done;

  // Next-state and datapath control; abort overrides everything outside IDLE.
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    n_d       = n_q;
    base_d    = base_q;
    res_d     = res_q;
    r_d       = r_q;
    bit_d     = bit_q;
    err_d     = err_q;
    err_p_d   = err_p_q;
    done_d    = 1'b0;
    ready_d   = ready_q;
    mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          c_d     = c;
          d_d     = d;
          n_d     = n;
          ready_d = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (n_q < KW'(2) || c_q >= n_q) begin
          err_p_d = 1'b1;
          res_d   = '0;
          state_d = ST_FIN;
        end else begin
          err_p_d   = 1'b0;
          res_d     = KW'(1);
          base_d    = c_q;
          bit_d     = '0;
          mul_start = 1'b1;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        if (mul_done) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        base_d = sq_p;
        if (d_q[bit_q]) res_d = pr_p;
        if (bit_q == IW'(KEY_WIDTH - 1)) begin
          state_d = ST_FIN;
        end else begin
          bit_d     = bit_q + IW'(1);
          mul_start = 1'b1;
          state_d   = ST_CALC;
        end
      end
      ST_FIN: begin
        r_d     = res_q;
        err_d   = err_p_q;
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      ready_d   = 1'b1;
      done_d    = 1'b0;
      mul_start = 1'b0;
      r_d       = r_q;
      err_d     = err_q;
    end
  end

  // FSM, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      res_q   <= '0;
      r_q     <= '0;
      bit_q   <= '0;
      err_q   <= 1'b0;
      err_p_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      n_q     <= n_d;
      base_q  <= base_d;
      res_q   <= res_d;
      r_q     <= r_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
      err_p_q <= err_p_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  rsa_modmul_serial #(.W(KW)) u_mul_pr (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (res_d),
    .b     (base_d),
    .n     (n_q),
    .done  (pr_done),
    .p     (pr_p)
  );

  rsa_modmul_serial #(.W(KW)) u_mul_sq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (base_d),
    .b     (base_d),
    .n     (n_q),
    .done  (sq_done),
    .p     (sq_p)
  );

  assign ready = ready_q;
  assign done  = done_q;
  assign err   = err_q;
  assign r     = r_q;

`ifdef RSA_MODEXP_CYCLE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Count from the accept edge through the done edge, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      if (start && !abort) cnt_d = 32'd1;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Self-checking bench for rsa_modexp_engine at KEY_WIDTH=8.
// Directed vector table, hand-written corner sequences, random ops vs. model.
module tb_rsa_modexp_engine;

  localparam int KW  = 8;
  localparam int LAT = KW * (KW + 1) + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [KW-1:0] c = '0, d = '0, n = '0;
  logic          ready, done, err;
  logic [KW-1:0] r;
`ifdef RSA_MODEXP_CYCLE_CNT_EN
  logic [31:0]   cycle_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rsa_modexp_engine #(.KEY_WIDTH(KW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .c         (c),
    .d         (d),
    .n         (n),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .r         (r)
`ifdef RSA_MODEXP_CYCLE_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  typedef struct {
    int c, d, n, er, ee, lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model(input int cc, input int dd, input int nn,
                               output int ee);
    longint acc;
    if (nn < 2 || cc >= nn) begin
      ee = 1;
      return 0;
    end
    ee  = 0;
    acc = 1;
    for (int i = 0; i < dd; i++) acc = (acc * cc) % nn;
    return int'(acc % nn);
  endfunction

  // Drive operands, pulse start across one edge (the accept edge).
  task automatic accept(input int cc, input int dd, input int nn);
    c     = KW'(cc);
    d     = KW'(dd);
    n     = KW'(nn);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c     = '0;
    d     = '0;
    n     = '0;
  endtask

  // Edges from accept to done; -1 on timeout.
  task automatic wait_done(input int k0, output int lat);
    lat = -1;
    for (int k = k0 + 1; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string nm, input int cc, input int dd,
                        input int nn, input int er, input int ee,
                        input int el);
    int lat;
    chk({nm, ".ready"}, ready, 1);
    accept(cc, dd, nn);
    wait_done(0, lat);
    chk({nm, ".lat"}, lat, el);
    chk({nm, ".r"}, r, er);
    chk({nm, ".err"}, err, ee);
    @(posedge clk);
    #1;
    chk({nm, ".pulse"}, done, 0);
    chk({nm, ".hold"}, r, er);
  endtask

  vec_t tbl[$];

  initial begin
    int lat, er, ee, cc, dd, nn;
    bit seen;

    tbl.push_back('{5, 3, 33, 26, 0, LAT});
    tbl.push_back('{7, 0, 33, 1, 0, LAT});
    tbl.push_back('{40, 3, 33, 0, 1, 2});
    tbl.push_back('{5, 3, 33, 26, 0, LAT});
    tbl.push_back('{33, 1, 33, 0, 1, 2});
    tbl.push_back('{3, 5, 1, 0, 1, 2});
    tbl.push_back('{0, 0, 0, 0, 1, 2});
    tbl.push_back('{0, 5, 33, 0, 0, LAT});
    tbl.push_back('{1, 255, 2, 1, 0, LAT});
    tbl.push_back('{254, 255, 255, 254, 0, LAT});
    tbl.push_back('{2, 10, 251, 20, 0, LAT});

    #12;
    chk("rst.ready", ready, 1);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.r", r, 0);
`ifdef RSA_MODEXP_CYCLE_CNT_EN
    chk("rst.cnt", cycle_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Accepted on the very first edge after reset release.
    run_op("first", 5, 3, 33, 26, 0, LAT);
`ifdef RSA_MODEXP_CYCLE_CNT_EN
    chk("cnt", cycle_cnt, 75);
`endif

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].c, tbl[i].d, tbl[i].n,
             tbl[i].er, tbl[i].ee, tbl[i].lat);

    // Abort 20 cycles in: no done, ready next cycle, r/err retained.
    run_op("pre_ab", 5, 3, 33, 26, 0, LAT);
    accept(7, 5, 33);
    seen = 0;
    repeat (19) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("ab.ready", ready, 1);
    chk("ab.done", seen | done, 0);
    chk("ab.r", r, 26);
    chk("ab.err", err, 0);
    run_op("post_ab", 7, 5, 33, 10, 0, LAT);

    // Abort together with start in IDLE: nothing accepted.
    abort = 1'b1;
    accept(5, 3, 33);
    abort = 1'b0;
    chk("ab_idle.ready", ready, 1);
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    chk("ab_idle.done", seen, 0);

    // Start re-pulsed mid-operation is ignored.
    accept(5, 3, 33);
    repeat (9) @(posedge clk);
    #1;
    accept(7, 0, 33);
    wait_done(10, lat);
    chk("repulse.lat", lat, LAT);
    chk("repulse.r", r, 26);

    // Reset mid-operation abandons silently.
    @(posedge clk);
    #1;
    accept(3, 7, 35);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst.r", r, 0);
    chk("mrst.ready", ready, 1);
    chk("mrst.done", done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op("post_rst", 3, 7, 35, 17, 0, LAT);

    // Random operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      nn = $urandom_range(255, 0);
      if (nn < 2 || $urandom_range(4, 0) == 0) cc = $urandom_range(255, 0);
      else cc = $urandom_range(nn - 1, 0);
      dd = $urandom_range(255, 0);
      er = model(cc, dd, nn, ee);
      run_op($sformatf("rnd%0d", i), cc, dd, nn, er, ee, ee ? 2 : LAT);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_engine.md
RSA_MODEXP_ENGINE -- requirements
Module: rsa_modexp_engine

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 128: operand/key width in bits; legal range 8 to 2048.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; accepted only when ready=1.
REQ-005 SHALL have port abort, input, 1 bit: cancel the operation in flight.
REQ-006 SHALL have ports c, d and n, input, KEY_WIDTH bits each: message/ciphertext, exponent and modulus.
REQ-007 SHALL have port ready, output, 1 bit: engine idle and able to accept start.
REQ-008 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-009 SHALL have port err, output, 1 bit: last operation rejected because of invalid operands.
REQ-010 SHALL have port r, output, KEY_WIDTH bits: result c^d mod n.

Function
REQ-011 SHALL implement the FSM states IDLE, LOAD, CALC, UPDATE and FIN.
REQ-012 SHALL leave IDLE with ready=1 on start, capturing c, d and n into internal registers; later input changes SHALL be ignored.
REQ-013 SHALL, in LOAD, check that n>=2 and c<n; if invalid, go to FIN with r=0 and err=1 (latency 2 cycles); if valid, set result=1, base=c, clear err and set bit index to 0.
REQ-014 SHALL scan the exponent LSB first over exactly KEY_WIDTH bits, constant-time regardless of d.
REQ-015 SHALL, for each bit in CALC, run two modular multipliers in parallel for exactly KEY_WIDTH cycles: result*base mod n and base*base mod n.
REQ-016 SHALL, in UPDATE (1 cycle), set base to the square, set result to the product only if d[bit]=1, and advance the bit index; after bit KEY_WIDTH-1 go to FIN, otherwise return to CALC.
REQ-017 SHALL, in FIN, drive done=1 for one cycle, load r, and return to IDLE.
REQ-018 SHALL use a valid-operand latency, from the start-accept edge to the done-high edge, of KEY_WIDTH*(KEY_WIDTH+1)+2 cycles (74 cycles at KEY_WIDTH=8).
REQ-019 SHALL hold r and err stable from done until the next accepted start.
REQ-020 SHALL ignore start while ready=0, with no queuing.
REQ-021 SHALL, on abort in any non-IDLE state, go to IDLE on the next edge with no done pulse and r/err unchanged; abort in IDLE is a no-op; abort takes priority over start in the same cycle.
REQ-022 SHALL return r=1 for d=0 with valid operands.
REQ-023 SHALL use multiplier arithmetic that is MSB-first interleaved shift-add with an accumulator of KEY_WIDTH+2 bits and up to two conditional subtractions of n per step; the output is always < n.

Reset
REQ-024 SHALL, while rst_n=0, force FSM=IDLE, ready=1, done=0, err=0, r=0 and clear all internal registers; reset mid-operation abandons the operation silently.
REQ-025 SHALL accept start from the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL support macro RSA_MODEXP_CYCLE_CNT_EN: when defined, add output port cycle_cnt (32 bits, reset 0), which counts cycles from start-accept to done inclusive and is held until the next start; it saturates at 2^32-1.
REQ-027 SHALL, when RSA_MODEXP_CYCLE_CNT_EN is not defined, have no cycle_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-028 SHALL keep the FSM state enum typedef and the default KEY_WIDTH constant in shared package rsa_pkg.
REQ-029 SHALL implement the modular multiplier as sub-module rsa_modmul_serial (start/done handshake, KEY_WIDTH-cycle latency), instantiated twice.

Verification
REQ-030 SHALL cover, at KEY_WIDTH=8: c=5, d=3, n=33, start -> done after 74 cycles, r=26, err=0.
REQ-031 SHALL cover: c=7, d=0, n=33 -> r=1 after 74 cycles, err=0.
REQ-032 SHALL cover: c=40, n=33 (c>=n) -> done 2 cycles after accept, r=0, err=1; a follow-up valid op clears err.
REQ-033 SHALL cover: abort asserted 20 cycles into an op -> no done, ready=1 next cycle, r keeps its previous value; an immediate new start completes correctly.
REQ-034 SHALL cover: start re-pulsed mid-operation and rst_n pulsed low mid-operation -> the re-pulse is ignored, and reset forces r=0, ready=1, no done.
REQ-035 SHALL cover, with RSA_MODEXP_CYCLE_CNT_EN defined: the REQ-030 case reads cycle_cnt=75.
